i2s_sample_tx: RTL and testbench

Audio output back end of the MP3 player. The Nios II decoder writes packed 16-bit stereo PCM samples over an Avalon-MM slave into an internal FIFO. This block drains the FIFO and serialises one sample pair per frame onto a standard Philips I2S bus driving the codec DAC. It lives in FPGA fabric next to `mp3player_soc` and is exported as a memory-mapped peripheral on the Nios data bus.

---
 rtl/i2s_sample_tx.sv | 175 +++++++++++++++++
 tb/tb_i2s_sample_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// Avalon-MM fed stereo PCM FIFO drained one sample pair per frame onto a Philips I2S bus.
// Latency: push visible in STATUS next cycle; readdata 1 cycle after avs_read; frame pop at b 63->0 or enable.
// Backpressure: none on Avalon; DATA writes into a full FIFO are dropped and flag the sticky overflow bit.
module i2s_sample_tx #(
    parameter int FIFO_DEPTH = 64,
    parameter int SCLK_DIV   = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        i2s_sclk,
    output logic        i2s_lrclk,
    output logic        i2s_dout,
    output logic        irq
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [8:0] DEPTH_L = 9'(FIFO_DEPTH);
    localparam logic [8:0] HALF_L  = 9'(FIFO_DEPTH / 2);
    localparam logic [7:0] DIV_TC  = 8'(SCLK_DIV - 1);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    level;
    logic          empty;
    logic          full;

    logic          enable;
    logic          enable_d;
    logic          irq_en;
    logic          underrun;
    logic          overflow;

    logic [7:0]    div_cnt;
    logic [5:0]    bit_idx;
    logic [5:0]    bit_next;
    logic [31:0]   sample;
    logic          dout_next;

    logic          wr_data;
    logic          wr_ctrl;
    logic          div_tc;
    logic          sclk_fall;
    logic          frame_start;
    logic          pop;
    logic          push;
    logic [31:0]   status;

    assign empty    = (level == 9'd0);
    assign full     = (level == DEPTH_L);
    assign wr_data  = avs_write && (avs_address == 2'd0);
    assign wr_ctrl  = avs_write && (avs_address == 2'd2);
    assign div_tc   = enable && (div_cnt == DIV_TC);
    assign sclk_fall = div_tc && i2s_sclk;
    // A frame starts either on the first enabled cycle or when b wraps 63 -> 0.
    assign frame_start = enable && (!enable_d || (sclk_fall && (bit_idx == 6'd63)));
    assign pop      = frame_start && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
    assign push     = wr_data && (!full || pop);
    assign bit_next = bit_idx + 6'd1;
    assign status   = {19'd0, overflow, underrun, full, empty, level};

    // Serial data for the bit index about to start: MSB first, one bit after the lrclk change.
    always_comb begin
        dout_next = 1'b0;
        if ((bit_next >= 6'd1) && (bit_next <= 6'd16)) begin
            dout_next = sample[5'(6'd32 - bit_next)];
        end else if ((bit_next >= 6'd33) && (bit_next <= 6'd48)) begin
            dout_next = sample[5'(6'd48 - bit_next)];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= avs_writedata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 9'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + 9'd1;
            else if (pop && !push) level <= level - 9'd1;
        end
    end

    // CONTROL register, enable edge detect and sticky error flags (clear wins over a same-cycle set).
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            enable   <= 1'b0;
            enable_d <= 1'b0;
            irq_en   <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            enable_d <= enable;
            if (wr_ctrl) begin
                enable <= avs_writedata[0];
                irq_en <= avs_writedata[1];
            end
            if (wr_ctrl && avs_writedata[2]) begin
                underrun <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (frame_start && empty)       underrun <= 1'b1;
                if (wr_data && full && !pop)    overflow <= 1'b1;
            end
        end
    end

    // Bit clock divider and frame bit counter; everything parks at 0 while disabled.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || !enable) begin
            div_cnt   <= 8'd0;
            bit_idx   <= 6'd0;
            i2s_sclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_dout  <= 1'b0;
        end else if (div_tc) begin
            div_cnt  <= 8'd0;
            i2s_sclk <= ~i2s_sclk;
            if (i2s_sclk) begin
                bit_idx   <= bit_next;
                i2s_lrclk <= bit_next[5];
                i2s_dout  <= dout_next;
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Frame sample register: head of FIFO at frame start, silence on underrun.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sample <= 32'd0;
        end else if (frame_start) begin
            sample <= pop ? mem[rd_ptr] : 32'd0;
        end
    end

    // Registered Avalon read mux; value holds until the next read.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            case (avs_address)
                2'd1:    avs_readdata <= status;
                2'd2:    avs_readdata <= {30'd0, irq_en, enable};
                default: avs_readdata <= 32'd0;
            endcase
        end
    end

    // Level interrupt, registered so it lags level/CONTROL changes by one cycle.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && (level <= HALF_L);
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: queue-based model of FIFO/flags, frames decoded from captured SCLK-rising samples.
// Latency: all stimulus aligned 1 time unit after rising clk edges.
// Backpressure: not applicable; DATA writes beyond depth are modelled as dropped.
module tb_i2s_sample_tx;

    localparam int SD  = 16;
    localparam int FD  = 64;
    localparam int PER = 10;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic        m_ovf;
    logic        m_und;

    bit          rx_d[$];
    bit          rx_l[$];
    time         rx_t[$];
    time         last_wr_t;
    time         t_en;

    logic [31:0] rd;
    logic [31:0] w;
    logic [31:0] s0;
    logic [31:0] s1;

    i2s_sample_tx #(.FIFO_DEPTH(FD), .SCLK_DIV(SD)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .i2s_sclk      (i2s_sclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_dout      (i2s_dout),
        .irq           (irq)
    );

    always #(PER / 2) clk_clk = ~clk_clk;

    // What the DAC sees: one sample of lrclk/dout on every SCLK rising edge.
    always @(posedge i2s_sclk) begin
        rx_d.push_back(i2s_dout);
        rx_l.push_back(i2s_lrclk);
        rx_t.push_back($time);
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, observed time=%0t required<2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = mq.size();
        return {19'd0, m_ovf, m_und, (n == FD), (n == 0), 9'(n)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk_clk);
        last_wr_t = $time;
        #1;
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // Only used while no frames are running, so the model never sees a concurrent pop.
    task automatic push_word(input logic [31:0] d);
        avs_wr(2'd0, d);
        if (mq.size() < FD) mq.push_back(d);
        else                m_ovf = 1'b1;
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_l.delete();
        rx_t.delete();
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while ((rx_d.size() < n) && (k < 20000)) begin
            @(posedge clk_clk);
            #1;
            k++;
        end
        check("bits_seen", 64'(rx_d.size() >= n), 64'd1);
    endtask

    // Expected frame: idle bit, left MSB first, padding, idle bit, right MSB first, padding.
    task automatic compare_frame(input int f, input logic [31:0] s, input string tag);
        logic [63:0] cd;
        logic [63:0] cl;
        cd = '0;
        cl = '0;
        if (rx_d.size() < (f + 1) * 64) return;
        for (int i = 0; i < 64; i++) begin
            cd = {cd[62:0], rx_d[f * 64 + i]};
            cl = {cl[62:0], rx_l[f * 64 + i]};
        end
        check({tag, "_dout"}, cd, {1'b0, s[31:16], 15'd0, 1'b0, s[15:0], 15'd0});
        check({tag, "_lrclk"}, cl, {32'h0000_0000, 32'hFFFF_FFFF});
    endtask

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = 2'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        avs_read      = 1'b0;
        m_ovf         = 1'b0;
        m_und         = 1'b0;

        // Reset with random bus activity.
        for (int i = 0; i < 4; i++) begin
            avs_address   = 2'($urandom);
            avs_writedata = $urandom;
            avs_write     = 1'b1;
            avs_read      = 1'b1;
            @(posedge clk_clk);
            #1;
        end
        check("reset_outputs", 64'({avs_readdata, i2s_sclk, i2s_lrclk, i2s_dout, irq}), 64'd0);
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        reset_reset_n = 1'b1;
        avs_rd(2'd1, rd);
        check("reset_status", 64'(rd), 64'h200);

        // Serialisation of a known pattern and a random word, then an underrun frame.
        push_word(32'h8001_7FFE);
        w = $urandom;
        push_word(w);
        avs_rd(2'd1, rd);
        check("status_two", 64'(rd), 64'(exp_status()));
        clear_rx();
        avs_wr(2'd2, 32'h1);
        t_en = last_wr_t;
        wait_bits(192);
        avs_wr(2'd2, 32'h0);
        s0 = mq.pop_front();
        s1 = mq.pop_front();
        m_und = 1'b1;
        compare_frame(0, s0, "frame_a0");
        compare_frame(1, s1, "frame_a1");
        compare_frame(2, 32'd0, "frame_a2_underrun");
        if (rx_t.size() >= 2) begin
            check("first_rise", 64'(rx_t[0] - t_en), 64'(SD * PER));
            check("sclk_period", 64'(rx_t[1] - rx_t[0]), 64'(2 * SD * PER));
        end
        tick(3);
        check("disabled_pins", 64'({i2s_sclk, i2s_lrclk, i2s_dout}), 64'd0);
        avs_rd(2'd1, rd);
        check("status_after_a", 64'(rd), 64'(exp_status()));

        // Enable with an empty FIFO, then clear the sticky flag while enabled.
        clear_rx();
        avs_wr(2'd2, 32'h1);
        wait_bits(64);
        compare_frame(0, 32'd0, "frame_b_empty");
        tick(40);
        avs_rd(2'd1, rd);
        check("underrun_set", 64'(rd), 64'(exp_status()));
        avs_wr(2'd2, 32'h5);
        m_und = 1'b0;
        avs_rd(2'd1, rd);
        check("underrun_clear", 64'(rd), 64'(exp_status()));
        avs_rd(2'd2, rd);
        check("ctrl_enable_kept", 64'(rd), 64'h1);
        avs_wr(2'd2, 32'h0);
        tick(3);

        // Overflow with 65 random words while disabled.
        for (int i = 0; i < FD + 1; i++) begin
            w = $urandom;
            push_word(w);
        end
        avs_rd(2'd1, rd);
        check("overflow_status", 64'(rd), 64'(exp_status()));
        tick(5);
        check("readdata_hold", 64'(avs_readdata), 64'(exp_status()));
        avs_rd(2'd0, rd);
        check("read_data_addr", 64'(rd), 64'd0);
        avs_rd(2'd3, rd);
        check("read_addr3", 64'(rd), 64'd0);
        avs_wr(2'd2, 32'h4);
        m_ovf = 1'b0;
        avs_rd(2'd1, rd);
        check("sticky_clear", 64'(rd), 64'(exp_status()));

        // DATA write on the enable frame-start cycle with a full FIFO.
        clear_rx();
        avs_wr(2'd2, 32'h1);
        t_en = last_wr_t;
        w = $urandom;
        avs_wr(2'd0, w);
        s0 = mq.pop_front();
        mq.push_back(w);
        avs_rd(2'd1, rd);
        check("push_pop_full", 64'(rd), 64'(exp_status()));
        wait_bits(128);
        s1 = mq.pop_front();
        avs_rd(2'd1, rd);
        check("level_after_d", 64'(rd), 64'(exp_status()));
        compare_frame(0, s0, "frame_d0");
        compare_frame(1, s1, "frame_d1");
        if (rx_t.size() >= 1) check("first_rise_d", 64'(rx_t[0] - t_en), 64'(SD * PER));

        // Reset mid-frame against a concurrent DATA write.
        reset_reset_n = 1'b0;
        avs_address   = 2'd0;
        avs_writedata = $urandom;
        avs_write     = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
        tick(1);
        check("midframe_reset_pins", 64'({avs_readdata, i2s_sclk, i2s_lrclk, i2s_dout, irq}), 64'd0);
        reset_reset_n = 1'b1;
        mq.delete();
        m_und = 1'b0;
        m_ovf = 1'b0;
        avs_rd(2'd1, rd);
        check("midframe_reset_status", 64'(rd), 64'h200);
        avs_rd(2'd2, rd);
        check("reset_ctrl", 64'(rd), 64'd0);

        // IRQ threshold around half depth.
        avs_wr(2'd2, 32'h2);
        tick(2);
        check("irq_empty", 64'(irq), 64'd1);
        for (int i = 0; i < FD / 2; i++) begin
            w = $urandom;
            push_word(w);
        end
        tick(2);
        check("irq_level32", 64'(irq), 64'd1);
        w = $urandom;
        push_word(w);
        tick(2);
        check("irq_level33", 64'(irq), 64'd0);
        clear_rx();
        avs_wr(2'd2, 32'h3);
        tick(1);
        check("irq_at_pop", 64'(irq), 64'd0);
        tick(1);
        check("irq_after_pop", 64'(irq), 64'd1);
        s0 = mq.pop_front();
        wait_bits(64);
        avs_wr(2'd2, 32'h2);
        compare_frame(0, s0, "frame_e0");
        avs_rd(2'd1, rd);
        check("status_after_e", 64'(rd), 64'(exp_status()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
